// File: rtl/watchdog_gen_if.sv
// Watchdog bus bundle: tick strobe, 68k write decode inputs, control and status.
// Inputs sampled every CLK, status registered; no backpressure (strobes are never stalled).
interface watchdog_gen_if #(
   parameter int CNT_W = 4
);
   logic             TICK_EN;
   logic [22:0]      M68K_ADDR;
   logic             nLDS;
   logic             RW;
   logic             WD_ENABLE;
   logic             EXT_RST_n;
   logic             nRESET;
   logic             nHALT;
   logic             TRIPPED;
   logic [7:0]       TRIP_COUNT;
   logic [CNT_W-1:0] WD_CNT;

   modport master (
      output TICK_EN, M68K_ADDR, nLDS, RW, WD_ENABLE, EXT_RST_n,
      input  nRESET, nHALT, TRIPPED, TRIP_COUNT, WD_CNT
   );

   modport slave (
      input  TICK_EN, M68K_ADDR, nLDS, RW, WD_ENABLE, EXT_RST_n,
      output nRESET, nHALT, TRIPPED, TRIP_COUNT, WD_CNT
   );
endinterface

// File: rtl/watchdog_gen.sv
// 68k watchdog: trips after TIMEOUT ticks without a kick write, then holds nRESET/nHALT low HOLD ticks.
// Outputs change 1 CLK after the causing event; no backpressure, every tick/kick is consumed.
module watchdog_gen #(
   parameter int          CNT_W     = 4,
   parameter int          TIMEOUT   = 8,
   parameter int          HOLD      = 8,
   parameter logic [22:0] KICK_ADDR = 23'h180000,
   parameter logic [22:0] KICK_MASK = 23'h7F0000
) (
   input  logic           CLK,
   input  logic           RESET,
   watchdog_gen_if.slave  bus
);

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             nreset_q;
   logic             tripped_q;
   logic [7:0]       trip_cnt_q;
   logic             hit_q;
   logic             hit_d;
   logic             kick;

   // A write strobe may be held for several CLKs; only its first cycle counts as a kick.
   assign hit_d = ~bus.RW & ~bus.nLDS &
                  (((bus.M68K_ADDR ^ KICK_ADDR) & KICK_MASK) == 23'd0);
   assign kick  = hit_d & ~hit_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         nreset_q   <= 1'b0;
         tripped_q  <= 1'b0;
         trip_cnt_q <= 8'd0;
         hit_q      <= 1'b0;
      end else begin
         hit_q <= hit_d;
         if (!bus.EXT_RST_n) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            nreset_q <= 1'b0;
         end else if (state_q == ST_HOLD) begin
            if (bus.TICK_EN) begin
               if (cnt_q == HOLD_LAST) begin
                  state_q  <= ST_RUN;
                  cnt_q    <= '0;
                  nreset_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end else begin
            if (kick || !bus.WD_ENABLE) begin
               cnt_q <= '0;
            end else if (bus.TICK_EN) begin
               if (cnt_q == TIMEOUT_LAST) begin
                  state_q   <= ST_HOLD;
                  cnt_q     <= '0;
                  nreset_q  <= 1'b0;
                  tripped_q <= 1'b1;
                  if (trip_cnt_q != 8'hFF) begin
                     trip_cnt_q <= trip_cnt_q + 8'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

   assign bus.nRESET     = nreset_q;
   assign bus.nHALT      = nreset_q;
   assign bus.TRIPPED    = tripped_q;
   assign bus.TRIP_COUNT = trip_cnt_q;
   assign bus.WD_CNT     = cnt_q;

endmodule

// File: tb/tb_watchdog_gen.sv
// Bench for watchdog_gen: directed stimulus pushes expected status into a queue, a negedge monitor pops and compares.
// Two instances: default 8/8 timing, and TIMEOUT=HOLD=1 for trip counter saturation.
module tb_watchdog_gen;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   watchdog_gen_if #(.CNT_W(4)) b0 ();
   watchdog_gen_if #(.CNT_W(1)) b1 ();

   watchdog_gen #(.CNT_W(4), .TIMEOUT(8), .HOLD(8),
                  .KICK_ADDR(23'h180000), .KICK_MASK(23'h7F0000))
      dut0 (.CLK(clk), .RESET(rst), .bus(b0));

   watchdog_gen #(.CNT_W(1), .TIMEOUT(1), .HOLD(1),
                  .KICK_ADDR(23'h180000), .KICK_MASK(23'h7F0000))
      dut1 (.CLK(clk), .RESET(rst), .bus(b1));

   // Scoreboard entries: {nRESET, nHALT, TRIPPED, TRIP_COUNT[7:0], WD_CNT[3:0]}
   string       q_name[$];
   int          q_cyc[$];
   int          q_dut[$];
   logic [14:0] q_exp[$];

   function automatic void expect_st(int d, string n, logic nr, logic tr, int tc, int cnt);
      q_name.push_back(n);
      q_cyc.push_back(cyc);
      q_dut.push_back(d);
      q_exp.push_back({nr, nr, tr, 8'(tc), 4'(cnt)});
   endfunction

   function automatic logic [14:0] actual(int d);
      if (d == 0)
         return {b0.nRESET, b0.nHALT, b0.TRIPPED, b0.TRIP_COUNT, b0.WD_CNT};
      return {b1.nRESET, b1.nHALT, b1.TRIPPED, b1.TRIP_COUNT, 3'b000, b1.WD_CNT};
   endfunction

   always @(negedge clk) begin
      while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
         string       n;
         int          c;
         int          d;
         logic [14:0] e;
         logic [14:0] a;
         n = q_name.pop_front();
         c = q_cyc.pop_front();
         d = q_dut.pop_front();
         e = q_exp.pop_front();
         a = actual(d);
         n_chk++;
         if (c != cyc) begin
            n_fail++;
            $display("FAIL %s: check due at cycle %0d evaluated at cycle %0d", n, c, cyc);
         end else if (a !== e) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got nRESET=%b nHALT=%b TRIPPED=%b TRIP_COUNT=%0d WD_CNT=%0d, expected nRESET=%b nHALT=%b TRIPPED=%b TRIP_COUNT=%0d WD_CNT=%0d",
                     n, d, a[14], a[13], a[12], a[11:4], a[3:0], e[14], e[13], e[12], e[11:4], e[3:0]);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick0();
      b0.TICK_EN = 1'b1;
      cycle();
      b0.TICK_EN = 1'b0;
      repeat (9) cycle();
   endtask

   task automatic ticks0(int n);
      repeat (n) tick0();
   endtask

   task automatic bus_start(logic [22:0] addr, logic rw, logic with_tick);
      b0.M68K_ADDR = addr;
      b0.RW        = rw;
      b0.nLDS      = 1'b0;
      b0.TICK_EN   = with_tick;
      cycle();
      b0.TICK_EN   = 1'b0;
   endtask

   task automatic bus_end();
      b0.nLDS = 1'b1;
      b0.RW   = 1'b1;
      cycle();
   endtask

   initial begin
      rst = 1'b1;
      b0.TICK_EN = 1'b0; b0.M68K_ADDR = '0; b0.nLDS = 1'b1; b0.RW = 1'b1;
      b0.WD_ENABLE = 1'b1; b0.EXT_RST_n = 1'b1;
      b1.TICK_EN = 1'b0; b1.M68K_ADDR = '0; b1.nLDS = 1'b1; b1.RW = 1'b1;
      b1.WD_ENABLE = 1'b1; b1.EXT_RST_n = 1'b1;

      // Reset and the initial hold period
      repeat (2) cycle();
      expect_st(0, "reset0", 0, 0, 0, 0);
      expect_st(1, "reset1", 0, 0, 0, 0);
      rst = 1'b0;
      ticks0(7);
      expect_st(0, "hold_7", 0, 0, 0, 7);
      tick0();
      expect_st(0, "hold_done", 1, 0, 0, 0);

      // Unkicked timeouts
      ticks0(7);
      expect_st(0, "run_7", 1, 0, 0, 7);
      tick0();
      expect_st(0, "trip1", 0, 1, 1, 0);
      ticks0(7);
      expect_st(0, "trip1_hold_7", 0, 1, 1, 7);
      tick0();
      expect_st(0, "release1", 1, 1, 1, 0);
      ticks0(8);
      expect_st(0, "trip2", 0, 1, 2, 0);
      ticks0(8);
      expect_st(0, "release2", 1, 1, 2, 0);

      // Regular kicks at $300001 and $310001 keep it alive
      for (int k = 0; k < 3; k++) begin
         ticks0(7);
         bus_start((k == 1) ? 23'h188000 : 23'h180000, 1'b0, 1'b0);
         expect_st(0, "kick", 1, 1, 2, 0);
         bus_end();
      end
      ticks0(7);
      expect_st(0, "no_trip_7", 1, 1, 2, 7);

      // Kick coincident with the timeout tick
      bus_start(23'h180000, 1'b0, 1'b1);
      expect_st(0, "kick_tick", 1, 1, 2, 0);
      bus_end();
      tick0();
      expect_st(0, "after_kick_tick", 1, 1, 2, 1);

      // External reset held low 3 CLK, with a tick arriving meanwhile
      ticks0(2);
      b0.EXT_RST_n = 1'b0;
      cycle();
      expect_st(0, "ext_rst", 0, 1, 2, 0);
      b0.TICK_EN = 1'b1;
      cycle();
      b0.TICK_EN = 1'b0;
      expect_st(0, "ext_rst_tick", 0, 1, 2, 0);
      cycle();
      b0.EXT_RST_n = 1'b1;
      ticks0(7);
      expect_st(0, "ext_hold_7", 0, 1, 2, 7);
      tick0();
      expect_st(0, "ext_release", 1, 1, 2, 0);

      // $320001 write and $300001 read must not kick
      ticks0(7);
      bus_start(23'h190000, 1'b0, 1'b0);
      expect_st(0, "wr_320001", 1, 1, 2, 7);
      bus_end();
      bus_start(23'h180000, 1'b1, 1'b0);
      expect_st(0, "rd_300001", 1, 1, 2, 7);
      bus_end();
      tick0();
      expect_st(0, "trip3", 0, 1, 3, 0);
      ticks0(8);
      expect_st(0, "release3", 1, 1, 3, 0);

      // Enable handling
      ticks0(5);
      expect_st(0, "en_5", 1, 1, 3, 5);
      b0.WD_ENABLE = 1'b0;
      cycle();
      expect_st(0, "dis_clear", 1, 1, 3, 0);
      ticks0(100);
      expect_st(0, "dis_100", 1, 1, 3, 0);
      b0.WD_ENABLE = 1'b1;
      ticks0(3);
      expect_st(0, "reen_3", 1, 1, 3, 3);
      ticks0(4);
      expect_st(0, "pre_trip4", 1, 1, 3, 7);
      tick0();
      expect_st(0, "trip4", 0, 1, 4, 0);
      b0.WD_ENABLE = 1'b0;
      ticks0(8);
      expect_st(0, "hold_while_dis", 1, 1, 4, 0);
      b0.WD_ENABLE = 1'b1;

      // TIMEOUT=HOLD=1: one trip every two ticks, counter saturates
      for (int i = 1; i <= 600; i++) begin
         b1.TICK_EN = 1'b1;
         cycle();
         b1.TICK_EN = 1'b0;
         cycle();
         if (i == 1)   expect_st(1, "fast_run", 1, 0, 0, 0);
         if (i == 2)   expect_st(1, "fast_trip1", 0, 1, 1, 0);
         if (i == 508) expect_st(1, "fast_254", 0, 1, 254, 0);
         if (i == 600) expect_st(1, "fast_sat", 0, 1, 255, 0);
      end

      repeat (3) cycle();
      if (q_cyc.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d checks left unevaluated, required 0", q_cyc.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
